// File: rtl/fpu_host_driver.sv
// Host-side initiator for the FPU host port: sends two operand words, collects two result beats.
// Optional watchdog enabled by defining FPU_DRV_WATCHDOG_EN.
module fpu_host_driver #(
  parameter int unsigned TMO_W = 10
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  input  logic [2:0]  cmd_mode,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [2:0]  rsp_exc,
  output logic        rsp_tmo,
  output logic        CS,
  output logic        OPT,
  output logic [2:0]  MODE,
  output logic [31:0] DIN,
  output logic        DIV,
  input  logic        DACK,
  input  logic        DR,
  input  logic [15:0] DOUT,
  input  logic        DOV,
  output logic        DOA,
  input  logic        ABUSY,
  input  logic        MBUSY,
  input  logic [2:0]  EXC,
  output logic [2:0]  DBG_STATE
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StWaitFree = 3'd1,
    StSendA    = 3'd2,
    StSendB    = 3'd3,
    StWaitDr   = 3'd4,
    StRecvLo   = 3'd5,
    StRecvHi   = 3'd6,
    StResp     = 3'd7
  } state_e;

  state_e      state_q, state_d;
  logic        op_q, op_d;
  logic [2:0]  mode_q, mode_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] data_q, data_d;
  logic [2:0]  exc_q, exc_d;
  logic        tmo_q, tmo_d;
  logic        tmo_fire;
  logic        wd_expire;

  logic        cmd_ready_q, cmd_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        cs_q, cs_d;
  logic        div_q, div_d;
  logic        doa_q, doa_d;
  logic [31:0] din_q, din_d;

`ifdef FPU_DRV_WATCHDOG_EN
  localparam logic [TMO_W-1:0] WdMax = '1;

  logic [TMO_W-1:0] wd_cnt_q, wd_cnt_d;
  logic             wd_active;

  assign wd_active = (state_q != StIdle) && (state_q != StResp);
  // Expire on the (2^TMO_W-1)th consecutive cycle spent in one stalled state.
  assign wd_expire = wd_active && (wd_cnt_q == (WdMax - TMO_W'(1)));

  always_comb begin
    wd_cnt_d = '0;
    if (wd_active && (state_d == state_q)) begin
      wd_cnt_d = wd_cnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end
`else
  assign wd_expire = 1'b0;
`endif

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a handshake on the expiry edge takes priority over the watchdog
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (cmd_valid) state_d = StWaitFree;
      StWaitFree: if (!(op_q ? MBUSY : ABUSY)) state_d = StSendA;
      StSendA:    if (DACK) state_d = StSendB;
      StSendB:    if (DACK) state_d = StWaitDr;
      StWaitDr:   if (DR) state_d = StRecvLo;
      StRecvLo:   if (DOV) state_d = StRecvHi;
      StRecvHi:   if (DOV) state_d = StResp;
      StResp:     if (rsp_ready) state_d = StIdle;
    endcase
    tmo_fire = wd_expire && (state_d == state_q);
    if (tmo_fire) begin
      state_d = StResp;
    end
  end

  // Command latch and result capture
  always_comb begin
    op_d   = op_q;
    mode_d = mode_q;
    a_d    = a_q;
    b_d    = b_q;
    data_d = data_q;
    exc_d  = exc_q;
    tmo_d  = tmo_q;
    if (state_q == StIdle && cmd_valid) begin
      op_d   = cmd_op;
      mode_d = cmd_mode;
      a_d    = cmd_a;
      b_d    = cmd_b;
      tmo_d  = 1'b0;
    end
    if (state_q == StRecvLo && DOV) begin
      data_d[15:0] = DOUT;
      exc_d        = EXC;
    end
    if (state_q == StRecvHi && DOV) begin
      data_d[31:16] = DOUT;
    end
    if (tmo_fire) begin
      data_d = '0;
      exc_d  = '0;
      tmo_d  = 1'b1;
    end
  end

  // Outputs decoded from the next state so they are registered alongside it
  always_comb begin
    cmd_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    cs_d        = 1'b0;
    div_d       = 1'b0;
    doa_d       = 1'b0;
    din_d       = '0;
    unique case (state_d)
      StIdle:     cmd_ready_d = 1'b1;
      StWaitFree: cs_d = 1'b0;
      StSendA: begin
        cs_d  = 1'b1;
        div_d = 1'b1;
        din_d = a_d;
      end
      StSendB: begin
        cs_d  = 1'b1;
        div_d = 1'b1;
        din_d = b_d;
      end
      StWaitDr:   cs_d = 1'b1;
      StRecvLo, StRecvHi: begin
        cs_d  = 1'b1;
        doa_d = 1'b1;
      end
      StResp:     rsp_valid_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      op_q        <= 1'b0;
      mode_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      data_q      <= '0;
      exc_q       <= '0;
      tmo_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      cs_q        <= 1'b0;
      div_q       <= 1'b0;
      doa_q       <= 1'b0;
      din_q       <= '0;
    end else begin
      op_q        <= op_d;
      mode_q      <= mode_d;
      a_q         <= a_d;
      b_q         <= b_d;
      data_q      <= data_d;
      exc_q       <= exc_d;
      tmo_q       <= tmo_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      cs_q        <= cs_d;
      div_q       <= div_d;
      doa_q       <= doa_d;
      din_q       <= din_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = data_q;
  assign rsp_exc   = exc_q;
  assign rsp_tmo   = tmo_q;
  assign CS        = cs_q;
  assign OPT       = op_q;
  assign MODE      = mode_q;
  assign DIN       = din_q;
  assign DIV       = div_q;
  assign DOA       = doa_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_fpu_host_driver.sv
// Bench for fpu_host_driver: a delay-parameterised FPU responder plus latency/data expectations
// computed from the handshake delays. Watchdog case runs when FPU_DRV_WATCHDOG_EN is defined.
module tb_fpu_host_driver;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_op = 1'b0;
  logic [2:0]  cmd_mode = '0;
  logic [31:0] cmd_a = '0;
  logic [31:0] cmd_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [2:0]  rsp_exc;
  logic        rsp_tmo;
  logic        CS, OPT, DIV, DOA;
  logic [2:0]  MODE;
  logic [31:0] DIN;
  logic        DACK = 1'b0;
  logic        DR = 1'b0;
  logic [15:0] DOUT = '0;
  logic        DOV = 1'b0;
  logic        ABUSY = 1'b0;
  logic        MBUSY = 1'b0;
  logic [2:0]  EXC = '0;
  logic [2:0]  DBG_STATE;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  fpu_host_driver #(.TMO_W(4)) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_mode(cmd_mode),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_exc(rsp_exc),
    .rsp_tmo(rsp_tmo),
    .CS(CS), .OPT(OPT), .MODE(MODE), .DIN(DIN), .DIV(DIV), .DACK(DACK),
    .DR(DR), .DOUT(DOUT), .DOV(DOV), .DOA(DOA),
    .ABUSY(ABUSY), .MBUSY(MBUSY), .EXC(EXC), .DBG_STATE(DBG_STATE)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fpu_idle();
    ABUSY = 1'b0; MBUSY = 1'b0; DACK = 1'b0; DR = 1'b0; DOV = 1'b0; DOUT = '0; EXC = '0;
  endtask

  // busy: selected unit busy for cycles 1..busy after accept; d: DACK delay per word;
  // r: DR delay in WAIT_DR; g: cycles before each DOV; rdy: rsp_ready stall cycles.
  task automatic run_op(input logic op, input logic [2:0] mode, input logic [31:0] a,
                        input logic [31:0] b, input logic [15:0] lo, input logic [15:0] hi,
                        input logic [2:0] exc, input int busy, input int d, input int r,
                        input int g, input int rdy, input bit noise, input bit rst_hi,
                        input bit exp_tmo);
    int c, words, beats, dcnt, rcnt, gcnt, divc, wdc, exp_lat;
    bit div_seen, done;
    logic [31:0] exp_data;
    logic [2:0]  exp_exc;
    exp_data = exp_tmo ? 32'h0 : {hi, lo};
    exp_exc  = exp_tmo ? 3'h0 : exc;
    exp_lat  = exp_tmo ? (4 + busy + 2 * d + 15) : (7 + busy + 2 * d + r + 2 * g);
    c = 1; words = 0; beats = 0; dcnt = 0; rcnt = 0; gcnt = 0; divc = 0; wdc = 0;
    div_seen = 1'b0; done = 1'b0;

    @(negedge CLK);
    check("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_mode = mode; cmd_a = a; cmd_b = b;
    @(negedge CLK);
    // Scramble the command bus so only latched values can reach the FPU
    cmd_valid = 1'b0; cmd_op = ~op; cmd_mode = ~mode; cmd_a = $urandom; cmd_b = $urandom;

    while (!done) begin
      if (rsp_valid) begin
        check("latency", c, exp_lat);
        check("rsp_data", rsp_data, exp_data);
        check("rsp_exc", rsp_exc, exp_exc);
        check("rsp_tmo", rsp_tmo, exp_tmo);
        check("cs_in_resp", CS, 0);
        check("doa_in_resp", DOA, 0);
        check("div_in_resp", DIV, 0);
        check("ready_in_resp", cmd_ready, 0);
        check("dbg_resp", DBG_STATE, 7);
        check("div_cycles", divc, 2 * (d + 1));
        if (exp_tmo) check("wait_dr_cycles", wdc, 15);
        done = 1'b1;
      end else if (c > 400) begin
        check("response_timeout", 0, 1);
        fpu_idle();
        return;
      end else if (rst_hi && DBG_STATE == 3'd6) begin
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        fpu_idle();
        check("rst_cs", CS, 0);
        check("rst_doa", DOA, 0);
        check("rst_div", DIV, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_dbg", DBG_STATE, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        return;
      end else begin
        if (CS) begin
          check("opt_latched", OPT, op);
          check("mode_latched", MODE, mode);
        end
        if (div_seen && words < 2) check("div_hold", DIV, 1);
        if (words == 2 && beats == 1) check("doa_hold", DOA, 1);
        ABUSY = op ? 1'b1 : (c <= busy);
        MBUSY = op ? (c <= busy) : 1'b1;
        DACK = 1'b0; DR = 1'b0; DOV = 1'b0;
        DOUT = noise ? 16'hFFFF : 16'h0;
        EXC = 3'($urandom);
        if (DIV) begin
          if (!div_seen) check("div_rise", c, 2 + busy);
          check("din_word", DIN, (words == 0) ? a : b);
          div_seen = 1'b1;
          divc++;
          DACK = (dcnt == d);
          if (DACK) begin
            words++;
            dcnt = 0;
          end else begin
            dcnt++;
          end
        end else if (noise) begin
          DACK = 1'b1;
        end
        if (CS && !DIV && !DOA) begin
          DR = (rcnt >= r);
          rcnt++;
          wdc++;
        end
        if (DOA) begin
          DOV = (gcnt == g);
          DOUT = (beats == 0) ? lo : hi;
          if (beats == 0) EXC = exc;
          if (DOV) begin
            beats++;
            gcnt = 0;
          end else begin
            gcnt++;
          end
        end else if (noise) begin
          DOV = 1'b1;
        end
        @(negedge CLK);
        c++;
      end
    end

    fpu_idle();
    for (int k = 0; k < rdy; k++) begin
      @(negedge CLK);
      check("resp_held_valid", rsp_valid, 1);
      check("resp_held_data", rsp_data, exp_data);
      check("resp_held_exc", rsp_exc, exp_exc);
    end
    rsp_ready = 1'b1;
    @(negedge CLK);
    rsp_ready = 1'b0;
    check("resp_cleared", rsp_valid, 0);
    check("ready_after_resp", cmd_ready, 1);
    check("dbg_idle_after", DBG_STATE, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=stuck expected=finish");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_cs", CS, 0);
    check("reset_div", DIV, 0);
    check("reset_doa", DOA, 0);
    check("reset_din", DIN, 0);
    check("reset_dbg", DBG_STATE, 0);
    check("reset_rsp_data", rsp_data, 0);
    check("reset_rsp_exc", rsp_exc, 0);
    check("reset_rsp_tmo", rsp_tmo, 0);
    check("reset_opt", OPT, 0);
    check("reset_mode", MODE, 0);
    RST = 1'b0;

    // Zero-wait add: 1.0 + 2.0 = 3.0
    run_op(1'b0, 3'd0, 32'h3F800000, 32'h40000000, 16'h0000, 16'h4040, 3'd0,
           0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    // Multiply waits on MBUSY only; ABUSY held high throughout
    run_op(1'b1, 3'd2, 32'h40400000, 32'hC0A00000, 16'h1234, 16'hC170, 3'd1,
           5, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    // Slow DACK for both words
    run_op(1'b0, 3'd1, 32'hA5A5A5A5, 32'h5A5A5A5A, 16'h0F0F, 16'hF0F0, 3'd4,
           0, 3, 0, 0, 1, 1'b0, 1'b0, 1'b0);
    // DOV gaps with response stall
    run_op(1'b1, 3'd3, 32'h11111111, 32'h22222222, 16'hBEEF, 16'hDEAD, 3'b010,
           0, 0, 1, 2, 3, 1'b1, 1'b0, 1'b0);
    // Reset during RECV_HI, then a clean command
    run_op(1'b0, 3'd5, 32'h01234567, 32'h89ABCDEF, 16'h5555, 16'hAAAA, 3'd6,
           1, 1, 1, 1, 0, 1'b0, 1'b1, 1'b0);
    run_op(1'b0, 3'd5, 32'h01234567, 32'h89ABCDEF, 16'h5555, 16'hAAAA, 3'd6,
           0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      run_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
             16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)),
             int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end

`ifdef FPU_DRV_WATCHDOG_EN
    // DR never arrives: 15 cycles in WAIT_DR, then a timed-out response
    run_op(1'b1, 3'd0, 32'hCAFEF00D, 32'h0BADBEEF, 16'h1111, 16'h2222, 3'd7,
           0, 0, 1000, 0, 2, 1'b0, 1'b0, 1'b1);
    run_op(1'b0, 3'd4, 32'h3F800000, 32'h3F800000, 16'h0000, 16'h4000, 3'd0,
           0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
